sum_accumulator: RTL and testbench

Streaming 32-bit accumulator that sits directly downstream of `carry_select_adder` and uses it as its only datapath adder. It accepts a programmed number of operands over a valid/ready input stream. It feeds the running total and each new operand into the adder, and registers the adder's `sum` back as the new total. When the programmed count is reached, it presents the final total on a valid/ready output.

---
 rtl/sum_accum_pkg.sv | 12 +
 rtl/carry_select_adder.sv | 36 +++
 rtl/sum_accumulator.sv | 110 +++++++++++
 tb/tb_sum_accumulator.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sum_accum_pkg.sv
// Shared definitions for the streaming sum accumulator.
package sum_accum_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } sum_accum_state_t;

endpackage

// File: rtl/carry_select_adder.sv
// 32-bit carry-select adder: each 4-bit block precomputes both carry-in cases,
// and the incoming block carry picks one of them.
module carry_select_adder
  import sum_accum_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  localparam int BLK_W = 4;
  localparam int NBLK  = DATA_W / BLK_W;

  logic [NBLK-1:0] carry;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
      logic [BLK_W:0] s0;
      logic [BLK_W:0] s1;

      assign s0 = {1'b0, a[gi*BLK_W +: BLK_W]} + {1'b0, b[gi*BLK_W +: BLK_W]};
      assign s1 = {1'b0, a[gi*BLK_W +: BLK_W]} + {1'b0, b[gi*BLK_W +: BLK_W]}
                  + (BLK_W+1)'(1);

      assign sum[gi*BLK_W +: BLK_W] = carry[gi] ? s1[BLK_W-1:0] : s0[BLK_W-1:0];

      // The final carry-out is dropped: the sum is modulo 2^DATA_W.
      if (gi < NBLK - 1) begin : g_carry
        assign carry[gi+1] = carry[gi] ? s1[BLK_W] : s0[BLK_W];
      end
    end
  endgenerate

endmodule

// File: rtl/sum_accumulator.sv
// Streaming accumulator: sums a programmed number of operands through u_add.
// Optional sticky wrap flag on out_ovf when SUM_ACCUM_OVF_EN is defined.
module sum_accumulator
  import sum_accum_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_sum,
  output logic [COUNT_W-1:0] out_count,
  output logic               busy
`ifdef SUM_ACCUM_OVF_EN
  ,
  output logic               out_ovf
`endif
);

  sum_accum_state_t   state_reg, state_next;
  logic [DATA_W-1:0]  acc_reg;
  logic [COUNT_W-1:0] cnt_reg;
  logic [COUNT_W-1:0] remaining_reg;
  logic [DATA_W-1:0]  add_sum;
  logic               launch;
  logic               accept;

  carry_select_adder u_add (
    .a   (acc_reg),
    .b   (in_data),
    .sum (add_sum)
  );

  assign launch = (state_reg == IDLE) && start;
  assign accept = (state_reg == ACCUM) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && (remaining_reg == COUNT_W'(1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      remaining_reg <= '0;
    end else if (launch) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      remaining_reg <= len;
    end else if (accept) begin
      acc_reg       <= add_sum;
      cnt_reg       <= cnt_reg + COUNT_W'(1);
      remaining_reg <= remaining_reg - COUNT_W'(1);
    end
  end

`ifdef SUM_ACCUM_OVF_EN
  logic ovf_reg;

  // An unsigned add wrapped exactly when the result is smaller than the old total.
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      ovf_reg <= 1'b0;
    end else if (accept && (add_sum < acc_reg)) begin
      ovf_reg <= 1'b1;
    end
  end

  assign out_ovf = ovf_reg;
`endif

  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == ACCUM) || (state_reg == DONE);
  assign out_sum   = acc_reg;
  assign out_count = cnt_reg;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator; checks out_ovf when SUM_ACCUM_OVF_EN is defined.
module tb_sum_accumulator;

  localparam int COUNT_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [COUNT_W-1:0] len;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_data;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_sum;
  logic [COUNT_W-1:0] out_count;
  logic               busy;
`ifdef SUM_ACCUM_OVF_EN
  logic               out_ovf;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  sum_accumulator #(.COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .busy      (busy)
`ifdef SUM_ACCUM_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_out_sum"}, out_sum, 0);
    chk({tag, "_out_count"}, 32'(out_count), 0);
`ifdef SUM_ACCUM_OVF_EN
    chk({tag, "_out_ovf"}, 32'(out_ovf), 0);
`endif
  endtask

  // mode 0: back-to-back, 1: random bubbles, 2: follow vpat (then all-valid)
  task automatic run_job(input string tag, input logic [31:0] ops[$], input int mode,
                         input bit vpat[$], input int hold);
    int n = ops.size();
    longint unsigned total = 0;
    int accepted = 0;
    int cyc = 0;
    logic [31:0] exp_sum;
    foreach (ops[i]) total += longint'(ops[i]);
    exp_sum = total[31:0];

    start = 1'b1;
    len   = COUNT_W'(n);
    step();
    start = 1'b0;
    cyc   = 1;
    while (accepted < n && cyc < 1000) begin
      chk({tag, "_in_ready"}, 32'(in_ready), 1);
      chk({tag, "_busy"}, 32'(busy), 1);
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = 1'($urandom_range(0, 1));
        default: in_valid = (cyc - 1 < vpat.size()) ? vpat[cyc-1] : 1'b1;
      endcase
      in_data = in_valid ? ops[accepted] : $urandom;
      step();
      if (in_valid) accepted++;
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "_accepted"}, 32'(accepted), 32'(n));
    if (mode == 0) chk({tag, "_latency"}, 32'(cyc), 32'(n + 1));

    chk({tag, "_out_valid"}, 32'(out_valid), 1);
    chk({tag, "_in_ready_done"}, 32'(in_ready), 0);
    chk({tag, "_out_sum"}, out_sum, exp_sum);
    chk({tag, "_out_count"}, 32'(out_count), 32'(n));
`ifdef SUM_ACCUM_OVF_EN
    chk({tag, "_out_ovf"}, 32'(out_ovf), 32'(total > 64'hFFFF_FFFF));
`endif

    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = ~start;
      len       = COUNT_W'($urandom_range(0, 5));
      step();
      chk({tag, "_hold_valid"}, 32'(out_valid), 1);
      chk({tag, "_hold_sum"}, out_sum, exp_sum);
      chk({tag, "_hold_count"}, 32'(out_count), 32'(n));
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 0);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, 32'(out_valid), 0);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_idle_in_ready"}, 32'(in_ready), 0);
    $display("job %s len=%0d sum=0x%08h count=%0d", tag, n, out_sum, out_count);
  endtask

  initial begin
    logic [31:0] ops[$];
    bit vpat[$];

    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    chk_idle_outputs("reset");
    rst = 1'b0;
    step();

    ops = '{32'd1, 32'd2, 32'd3};
    vpat = {};
    run_job("len3", ops, 0, vpat, 0);

    ops = '{32'hFFFF_FFFF, 32'h0000_0002};
    run_job("wrap", ops, 0, vpat, 0);

    ops = {};
    run_job("len0", ops, 0, vpat, 0);

    ops  = '{32'd10, 32'd20, 32'd30, 32'd40};
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_job("bubbles", ops, 2, vpat, 0);
    vpat = {};

    ops = '{32'd5, 32'd6};
    run_job("hold", ops, 0, vpat, 5);

    // Reset in the middle of a job abandons it.
    start = 1'b1;
    len   = COUNT_W'(4);
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = $urandom | 32'h1;
    step();
    in_data  = $urandom;
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    chk_idle_outputs("midrst");
    rst = 1'b0;

    ops = '{32'd7};
    run_job("after_rst", ops, 0, vpat, 0);

    for (int j = 0; j < 8; j++) begin
      int n = $urandom_range(1, 12);
      ops = {};
      for (int k = 0; k < n; k++) ops.push_back($urandom);
      run_job($sformatf("rand%0d", j), ops, j % 2, vpat, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
